// File: rtl/ltl_mon_pkg.sv
// Shared types and default constants for the LTL monitor sequencer.
// The FSM state enum and the report entry layout live here.
package ltl_mon_pkg;

    localparam int DEF_NUM_REPORTS = 4;
    localparam int DEF_IDX_W       = 32;
    localparam int DEF_REPORT_LAT  = 1;
    localparam int DEF_RST_CYCLES  = 2;
    localparam int RPT_FIFO_DEPTH  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RST   = 2'd1,
        FEED  = 2'd2,
        STALL = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic [DEF_NUM_REPORTS-1:0] vec;
        logic [DEF_IDX_W-1:0]       idx;
    } rpt_entry_t;

endpackage

// File: rtl/ltl_report_fifo.sv
// Two-entry first-word-fall-through FIFO with synchronous flush.
// The head register drives dout directly; push and pop together are legal when full.
module ltl_report_fifo #(
    parameter int W = 36
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         do_push, do_pop;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
        do_pop  = pop && (cnt_q != 2'd0);
        do_push = push && ((cnt_q != 2'd2) || do_pop);
        if (flush) begin
            head_d = '0;
            cnt_d  = 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (cnt_q == 2'd0) head_d = din;
                    else               tail_d = din;
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    head_d = tail_q;
                    cnt_d  = cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        head_d = din;
                    end else begin
                        head_d = tail_q;
                        tail_d = din;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign valid = (cnt_q != 2'd0);
    assign dout  = head_q;
    assign count = cnt_q;

endmodule

// File: rtl/ltl_monitor_sequencer.sv
// Feeds a trace stream into one LTL automaton cluster and queues index-tagged reports.
//   state | meaning
//   IDLE  | after reset, automaton held in reset, no symbols accepted
//   RST   | automaton reset held for RST_CYCLES after trace_start
//   FEED  | symbols streamed one per cycle while the report queue has room
//   STALL | queue cannot absorb in-flight reports; pipe drains
module ltl_monitor_sequencer
    import ltl_mon_pkg::*;
#(
    parameter int NUM_REPORTS = DEF_NUM_REPORTS,
    parameter int IDX_W       = DEF_IDX_W,
    parameter int REPORT_LAT  = DEF_REPORT_LAT,
    parameter int RST_CYCLES  = DEF_RST_CYCLES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   trace_start,
    input  logic                   sym_valid,
    input  logic [7:0]             sym_data,
    output logic                   sym_ready,
    output logic                   aut_reset,
    output logic                   aut_run,
    output logic [7:0]             aut_symbols,
    input  logic [NUM_REPORTS-1:0] aut_report,
    output logic                   rpt_valid,
    input  logic                   rpt_ready,
    output logic [NUM_REPORTS-1:0] rpt_vec,
    output logic [IDX_W-1:0]       rpt_idx,
    output logic                   busy
);

    localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int ENT_W = NUM_REPORTS + IDX_W;

    seq_state_e                       state_q, state_d;
    logic [RC_W-1:0]                  rst_cnt_q, rst_cnt_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [7:0]                       sym_last_q, sym_last_d;
    logic [REPORT_LAT-1:0]            pipe_vld_q, pipe_vld_d;
    logic [REPORT_LAT-1:0][IDX_W-1:0] pipe_idx_q, pipe_idx_d;

    logic [1:0]       fifo_cnt;
    logic [ENT_W-1:0] fifo_dout;
    logic [7:0]       inflight, free_cnt;
    logic             room, hs, rpt_push;

    // Every in-flight slot may still push, so a new symbol needs strictly more free entries.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < REPORT_LAT; i++) begin
            inflight = inflight + 8'(pipe_vld_q[i]);
        end
        free_cnt = 8'(RPT_FIFO_DEPTH) - 8'(fifo_cnt);
        room     = free_cnt > inflight;
    end

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        sym_ready = 1'b0;
        aut_reset = 1'b0;
        case (state_q)
            IDLE: aut_reset = 1'b1;
            RST: begin
                aut_reset = 1'b1;
                if (rst_cnt_q == '0) state_d = FEED;
                else                 rst_cnt_d = rst_cnt_q - RC_W'(1);
            end
            FEED: begin
                sym_ready = room;
                if (!room) state_d = STALL;
            end
            STALL: if (room) state_d = FEED;
            default: state_d = IDLE;
        endcase
        if (trace_start) begin
            state_d   = RST;
            rst_cnt_d = RC_W'(RST_CYCLES - 1);
            sym_ready = 1'b0;
        end
    end

    always_comb begin
        hs          = sym_valid && sym_ready;
        aut_run     = hs;
        aut_symbols = hs ? sym_data : sym_last_q;
        sym_last_d  = aut_symbols;
        idx_d       = hs ? idx_q + IDX_W'(1) : idx_q;
        pipe_vld_d    = '0;
        pipe_idx_d    = pipe_idx_q;
        pipe_vld_d[0] = hs;
        pipe_idx_d[0] = idx_q;
        for (int i = 1; i < REPORT_LAT; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_idx_d[i] = pipe_idx_q[i-1];
        end
        if (trace_start) begin
            idx_d      = '0;
            pipe_vld_d = '0;
        end
        rpt_push = pipe_vld_q[REPORT_LAT-1] && (aut_report != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rst_cnt_q  <= '0;
            idx_q      <= '0;
            sym_last_q <= '0;
            pipe_vld_q <= '0;
            pipe_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            idx_q      <= idx_d;
            sym_last_q <= sym_last_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_idx_q <= pipe_idx_d;
        end
    end

    ltl_report_fifo #(.W(ENT_W)) u_rpt_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (trace_start),
        .push  (rpt_push),
        .din   ({aut_report, pipe_idx_q[REPORT_LAT-1]}),
        .pop   (rpt_valid && rpt_ready),
        .valid (rpt_valid),
        .dout  (fifo_dout),
        .count (fifo_cnt)
    );

    assign rpt_vec = fifo_dout[ENT_W-1 -: NUM_REPORTS];
    assign rpt_idx = fifo_dout[IDX_W-1:0];
    assign busy    = (state_q != IDLE) || (fifo_cnt != 2'd0);

endmodule

// File: tb/tb_ltl_monitor_sequencer.sv
// Scoreboard bench: a toy cluster model reports on symbols with bit 7 set; a 4-bit-index
// twin instance sees the same traffic so index wrap is exercised alongside the 32-bit one.
module tb_ltl_monitor_sequencer;
    import ltl_mon_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       trace_start = 1'b0;
    logic       sym_valid = 1'b0;
    logic [7:0] sym_data = 8'h00;
    logic       rpt_ready = 1'b0;
    logic [3:0] aut_report = 4'h0;

    logic        sym_ready, aut_reset, aut_run, rpt_valid, busy;
    logic [7:0]  aut_symbols;
    logic [3:0]  rpt_vec;
    logic [31:0] rpt_idx;

    logic       sym_ready_w4, aut_reset_w4, aut_run_w4, rpt_valid_w4, busy_w4;
    logic [7:0] aut_symbols_w4;
    logic [3:0] rpt_vec_w4;
    logic [3:0] rpt_idx_w4;

    int errors = 0;
    int checks = 0;
    int pops = 0;
    bit wrap_phase = 1'b0;
    logic [31:0] m_idx = '0;
    rpt_entry_t sb_q[$];

    always #5 clk = ~clk;

    ltl_monitor_sequencer dut (
        .clk(clk), .reset(reset), .trace_start(trace_start),
        .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(sym_ready),
        .aut_reset(aut_reset), .aut_run(aut_run), .aut_symbols(aut_symbols),
        .aut_report(aut_report), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
        .rpt_vec(rpt_vec), .rpt_idx(rpt_idx), .busy(busy)
    );

    ltl_monitor_sequencer #(.IDX_W(4)) dut_w4 (
        .clk(clk), .reset(reset), .trace_start(trace_start),
        .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(sym_ready_w4),
        .aut_reset(aut_reset_w4), .aut_run(aut_run_w4), .aut_symbols(aut_symbols_w4),
        .aut_report(aut_report), .rpt_valid(rpt_valid_w4), .rpt_ready(rpt_ready),
        .rpt_vec(rpt_vec_w4), .rpt_idx(rpt_idx_w4), .busy(busy_w4)
    );

    function automatic logic [3:0] rep_of(input logic [7:0] s);
        return s[7] ? (4'b0001 << s[1:0]) : 4'b0000;
    endfunction

    // One-cycle-latency cluster stand-in.
    always @(posedge clk) begin
        if (aut_reset) aut_report <= 4'h0;
        else           aut_report <= aut_run ? rep_of(aut_symbols) : 4'h0;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sym(input logic [7:0] d);
        int n;
        n = 0;
        sym_valid = 1'b1;
        sym_data  = d;
        @(negedge clk);
        while (!sym_ready && n < 100) begin
            next_cyc();
            @(negedge clk);
            n++;
        end
        chk("send_wait_ok", n < 100, 1);
        next_cyc();
        sym_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        sym_valid = 1'b0;
        rpt_ready = 1'b1;
        while ((sb_q.size() != 0 || rpt_valid) && n < 60) begin
            next_cyc();
            n++;
        end
        chk(tag, sb_q.size(), 0);
    endtask

    always @(negedge clk) begin
        rpt_entry_t e;
        if (reset) begin
            sb_q.delete();
            m_idx = '0;
        end else if (trace_start) begin
            sb_q.delete();
            m_idx = '0;
            pops  = 0;
        end else begin
            if (rpt_valid && rpt_ready) begin
                chk("sb_entry_expected", sb_q.size() > 0, 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("sb_vec", rpt_vec, e.vec);
                    chk("sb_idx", rpt_idx, e.idx);
                    chk("sb_vec_w4", rpt_vec_w4, e.vec);
                    chk("sb_idx_w4", rpt_idx_w4, e.idx[3:0]);
                    if (wrap_phase && pops == 16) chk("wrap_idx17_w4", rpt_idx_w4, 0);
                end
                pops++;
            end
            if (sym_valid && sym_ready) begin
                if (rep_of(sym_data) != 4'h0) begin
                    e.vec = rep_of(sym_data);
                    e.idx = m_idx;
                    sb_q.push_back(e);
                end
                m_idx = m_idx + 32'd1;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] last_sym;
        bit exp_run;

        repeat (3) next_cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_aut_reset", aut_reset, 1);
        chk("rst_aut_run", aut_run, 0);
        chk("rst_aut_symbols", aut_symbols, 0);
        chk("rst_sym_ready", sym_ready, 0);
        chk("rst_rpt_valid", rpt_valid, 0);
        chk("rst_rpt_vec", rpt_vec, 0);
        chk("rst_rpt_idx", rpt_idx, 0);
        chk("rst_busy", busy, 0);

        // trace_start with no symbols
        next_cyc();
        trace_start = 1'b1;
        @(negedge clk);
        chk("ts_ready_t", sym_ready, 0);
        next_cyc();
        trace_start = 1'b0;
        @(negedge clk);
        chk("ts_aut_reset_t1", aut_reset, 1);
        chk("ts_ready_t1", sym_ready, 0);
        next_cyc();
        @(negedge clk);
        chk("ts_aut_reset_t2", aut_reset, 1);
        chk("ts_ready_t2", sym_ready, 0);
        next_cyc();
        @(negedge clk);
        chk("ts_aut_reset_t3", aut_reset, 0);
        chk("ts_ready_t3", sym_ready, 1);
        chk("ts_rpt_valid", rpt_valid, 0);
        chk("ts_busy", busy, 1);

        // 0x90 then 0x05 back-to-back
        next_cyc();
        sym_valid = 1'b1;
        sym_data  = 8'h90;
        rpt_ready = 1'b1;
        @(negedge clk);
        chk("b2b_ready0", sym_ready, 1);
        chk("b2b_run0", aut_run, 1);
        chk("b2b_sym0", aut_symbols, 8'h90);
        next_cyc();
        sym_data = 8'h05;
        @(negedge clk);
        chk("b2b_run1", aut_run, 1);
        chk("b2b_sym1", aut_symbols, 8'h05);
        next_cyc();
        sym_valid = 1'b0;
        @(negedge clk);
        chk("b2b_rpt_valid", rpt_valid, 1);
        chk("b2b_rpt_vec", rpt_vec, 4'b0001);
        chk("b2b_rpt_idx", rpt_idx, 0);
        next_cyc();
        @(negedge clk);
        chk("b2b_rpt_valid_after", rpt_valid, 0);

        // sym_valid toggling, non-reporting symbols
        last_sym = 8'h05;
        for (int i = 0; i < 8; i++) begin
            next_cyc();
            exp_run   = ((i % 2) == 0);
            sym_valid = exp_run;
            sym_data  = 8'h10 + 8'(i);
            @(negedge clk);
            if (exp_run) last_sym = 8'h10 + 8'(i);
            chk("tog_ready", sym_ready, 1);
            chk("tog_run", aut_run, exp_run);
            chk("tog_symbols", aut_symbols, last_sym);
        end
        next_cyc();
        sym_valid = 1'b0;
        rpt_ready = 1'b0;

        // 20 reporting symbols with the consumer blocked at first
        send_sym(8'h80);
        send_sym(8'h81);
        sym_valid = 1'b1;
        sym_data  = 8'h82;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_ready_low", sym_ready, 0);
            next_cyc();
        end
        @(negedge clk);
        chk("bp_rpt_valid", rpt_valid, 1);
        next_cyc();
        rpt_ready = 1'b1;
        for (int k = 2; k < 20; k++) send_sym(8'h80 + 8'(k));
        drain("bp_none_lost");

        // trace_start with two entries queued, plus a colliding handshake
        next_cyc();
        rpt_ready = 1'b0;
        send_sym(8'h81);
        send_sym(8'h82);
        next_cyc();
        @(negedge clk);
        chk("flush_pre_valid", rpt_valid, 1);
        next_cyc();
        trace_start = 1'b1;
        sym_valid   = 1'b1;
        sym_data    = 8'h83;
        rpt_ready   = 1'b1;
        @(negedge clk);
        chk("flush_ready_forced", sym_ready, 0);
        next_cyc();
        trace_start = 1'b0;
        @(negedge clk);
        chk("flush_rpt_valid", rpt_valid, 0);
        send_sym(8'h83);
        next_cyc();
        @(negedge clk);
        chk("restart_rpt_valid", rpt_valid, 1);
        chk("restart_rpt_vec", rpt_vec, 4'b1000);
        chk("restart_rpt_idx", rpt_idx, 0);
        drain("restart_drain");

        // 17 reporting symbols on a fresh trace: the 4-bit index wraps
        next_cyc();
        trace_start = 1'b1;
        next_cyc();
        trace_start = 1'b0;
        wrap_phase  = 1'b1;
        for (int k = 0; k < 17; k++) send_sym(8'h80 + 8'(k));
        drain("wrap_drain");
        chk("wrap_count", pops, 17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
